ahbl_input_stage: RTL and testbench

Per-master AHB-Lite address-phase input stage placed between one AHB-Lite master and the bus mux. It captures the master's address phase whenever the mux cannot take it in the cycle it is issued. It replays the captured phase to the mux and stalls the master through HREADYOUT until the transfer's data phase completes. It optionally rejects misaligned or oversized transfers locally with a two-cycle ERROR response.

---
 rtl/ahbl_input_stage.sv | 127 ++++++++++++
 tb/tb_ahbl_input_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_input_stage.sv
// AHB-Lite per-master address-phase input stage: holds phases the mux cannot take,
// stalls the master, optional local alignment ERROR (AHBL_INPUT_STAGE_ALIGN_CHK_EN).
package ahbl_bus_mux_defines;
  typedef struct packed {
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
  } aphase_t;
endpackage

module ahbl_input_stage
  import ahbl_bus_mux_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M_HADDR,
  input  logic [2:0]  M_HBURST,
  input  logic        M_HMASTLOCK,
  input  logic [3:0]  M_HPROT,
  input  logic [2:0]  M_HSIZE,
  input  logic [1:0]  M_HTRANS,
  input  logic        M_HWRITE,
  output logic        M_HREADYOUT,
  output logic        M_HRESP,
  output aphase_t     out_aphase,
  output logic        out_req,
  input  logic        mux_accept,
  input  logic        dphase_active,
  input  logic        S_HREADY,
  input  logic        S_HRESP
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]  HTRANS_SEQ    = 2'b11;
  localparam logic [2:0]  HBURST_INCR   = 3'b001;

  typedef enum logic [1:0] {NORM, ERR1, ERR2} rsp_state_t;

  rsp_state_t rsp_state;
  logic       hold_valid;
  aphase_t    hold_reg;
  aphase_t    live_aphase;
  aphase_t    store_aphase;
  logic       live_req;
  logic       legal;

  assign live_aphase = '{haddr: M_HADDR, hburst: M_HBURST, hmastlock: M_HMASTLOCK,
                         hprot: M_HPROT, hsize: M_HSIZE, htrans: M_HTRANS,
                         hwrite: M_HWRITE};

  // A held SEQ beat is replayed as the start of an undefined-length INCR burst
  always_comb begin
    store_aphase = live_aphase;
    if (M_HTRANS == HTRANS_SEQ) begin
      store_aphase.htrans = HTRANS_NONSEQ;
      store_aphase.hburst = HBURST_INCR;
    end
  end

  assign live_req = M_HREADYOUT & M_HTRANS[1];

`ifdef AHBL_INPUT_STAGE_ALIGN_CHK_EN
  logic [31:0] addr_mask;
  always_comb begin
    addr_mask = (32'(1) << M_HSIZE) - 32'(1);
    legal     = (32'(M_HSIZE) <= MAX_SIZE) && ((M_HADDR & addr_mask) == 32'(0));
  end
`else
  assign legal = 1'b1;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_valid <= 1'b0;
      hold_reg   <= '0;
      rsp_state  <= NORM;
    end else begin
      if (hold_valid && mux_accept) begin
        hold_valid <= 1'b0;
      end else if (live_req && legal && !mux_accept && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_reg   <= store_aphase;
      end
`ifdef AHBL_INPUT_STAGE_ALIGN_CHK_EN
      // ERR2 drives HREADYOUT high, so a new illegal phase there restarts the response
      case (rsp_state)
        NORM:    rsp_state <= (live_req && !legal) ? ERR1 : NORM;
        ERR1:    rsp_state <= ERR2;
        ERR2:    rsp_state <= (live_req && !legal) ? ERR1 : NORM;
        default: rsp_state <= NORM;
      endcase
`else
      rsp_state <= NORM;
`endif
    end
  end

  // Master-side response; forced idle-ready while reset is asserted
  always_comb begin
    M_HREADYOUT = 1'b1;
    M_HRESP     = 1'b0;
    if (HRESETn) begin
      if (rsp_state == ERR1) begin
        M_HREADYOUT = 1'b0;
        M_HRESP     = 1'b1;
      end else if (rsp_state == ERR2) begin
        M_HREADYOUT = 1'b1;
        M_HRESP     = 1'b1;
      end else begin
        if (hold_valid)         M_HREADYOUT = 1'b0;
        else if (dphase_active) M_HREADYOUT = S_HREADY;
        if (dphase_active)      M_HRESP     = S_HRESP;
      end
    end
  end

  assign out_aphase = hold_valid ? hold_reg : live_aphase;
  assign out_req    = HRESETn & (hold_valid | (live_req & legal));

endmodule

// File: tb/tb_ahbl_input_stage.sv
// Bench for ahbl_input_stage: directed vector table, reset-mid-hold sequence and
// randomized cycles checked against a transaction-level reference model.
module tb_ahbl_input_stage;
  import ahbl_bus_mux_defines::*;

`ifdef AHBL_INPUT_STAGE_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        HCLK, HRESETn;
  logic [31:0] M_HADDR;
  logic [2:0]  M_HBURST, M_HSIZE;
  logic        M_HMASTLOCK, M_HWRITE;
  logic [3:0]  M_HPROT;
  logic [1:0]  M_HTRANS;
  logic        M_HREADYOUT, M_HRESP, out_req;
  aphase_t     out_aphase;
  logic        mux_accept, dphase_active, S_HREADY, S_HRESP;

  ahbl_input_stage #(.DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_HADDR(M_HADDR), .M_HBURST(M_HBURST), .M_HMASTLOCK(M_HMASTLOCK),
    .M_HPROT(M_HPROT), .M_HSIZE(M_HSIZE), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
    .M_HREADYOUT(M_HREADYOUT), .M_HRESP(M_HRESP),
    .out_aphase(out_aphase), .out_req(out_req),
    .mux_accept(mux_accept), .dphase_active(dphase_active),
    .S_HREADY(S_HREADY), .S_HRESP(S_HRESP)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic        rst_n;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic        hwrite;
    logic [3:0]  hprot;
    logic        lock;
    logic        acc;
    logic        dph;
    logic        shr;
    logic        shp;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  e_rdy;
    logic  e_rsp;
    logic  e_req;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending held transfers and remaining error-response cycles
  aphase_t m_held[$];
  int      m_err = 0;
  logic    obs_rdy, obs_rsp, obs_req;

  function automatic aphase_t as_phase(input stim_t s);
    aphase_t a;
    a.haddr = s.haddr; a.hburst = s.hburst; a.hmastlock = s.lock; a.hprot = s.hprot;
    a.hsize = s.hsize; a.htrans = s.htrans; a.hwrite = s.hwrite;
    return a;
  endfunction

  function automatic bit model_legal(input stim_t s);
    int unsigned bytes;
    if (!CHK) return 1'b1;
    bytes = 1 << s.hsize;
    return (bytes <= 4) && ((s.haddr % bytes) == 0);
  endfunction

  function automatic stim_t mk(input logic [1:0] htrans, input logic [2:0] hburst,
                               input logic [2:0] hsize, input logic [31:0] haddr,
                               input logic hwrite, input logic acc, input logic dph,
                               input logic shr, input logic shp);
    stim_t s;
    s.rst_n = 1'b1; s.htrans = htrans; s.hburst = hburst; s.hsize = hsize;
    s.haddr = haddr; s.hwrite = hwrite; s.hprot = 4'h3; s.lock = 1'b0;
    s.acc = acc; s.dph = dph; s.shr = shr; s.shp = shp;
    return s;
  endfunction

  function automatic vec_t mv(input stim_t s, input logic r, input logic p, input logic q);
    vec_t v;
    v.s = s; v.e_rdy = r; v.e_rsp = p; v.e_req = q;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, compare against model, advance model at posedge
  task automatic cycle(input stim_t s);
    logic    er, ep, eq, live, lg;
    aphase_t ea, st;
    @(negedge HCLK);
    HRESETn = s.rst_n; M_HTRANS = s.htrans; M_HBURST = s.hburst; M_HSIZE = s.hsize;
    M_HADDR = s.haddr; M_HWRITE = s.hwrite; M_HPROT = s.hprot; M_HMASTLOCK = s.lock;
    mux_accept = s.acc; dphase_active = s.dph; S_HREADY = s.shr; S_HRESP = s.shp;
    #1;
    lg = model_legal(s);
    if (!s.rst_n) begin
      m_held.delete(); m_err = 0;
      er = 1'b1; ep = 1'b0; eq = 1'b0; live = 1'b0;
      ea = as_phase(s);
    end else begin
      if (m_err == 2)      begin er = 1'b0; ep = 1'b1; end
      else if (m_err == 1) begin er = 1'b1; ep = 1'b1; end
      else begin
        er = (m_held.size() != 0) ? 1'b0 : (s.dph ? s.shr : 1'b1);
        ep = s.dph ? s.shp : 1'b0;
      end
      live = er && s.htrans[1];
      eq = (m_held.size() != 0) || (live && lg);
      ea = (m_held.size() != 0) ? m_held[0] : as_phase(s);
    end
    obs_rdy = M_HREADYOUT; obs_rsp = M_HRESP; obs_req = out_req;
    check("hreadyout", 64'(M_HREADYOUT), 64'(er));
    check("hresp", 64'(M_HRESP), 64'(ep));
    check("out_req", 64'(out_req), 64'(eq));
    check("out_aphase", 64'(out_aphase), 64'(ea));
    @(posedge HCLK);
    if (s.rst_n) begin
      if (m_held.size() != 0) begin
        if (s.acc) void'(m_held.pop_front());
      end else if (live && lg && !s.acc) begin
        st = as_phase(s);
        if (s.htrans == 2'b11) begin st.htrans = 2'b10; st.hburst = 3'b001; end
        m_held.push_back(st);
      end
      if (live && !lg)     m_err = 2;
      else if (m_err > 0)  m_err--;
    end
  endtask

  vec_t  tbl[$];
  stim_t rs;

  initial begin
    HRESETn = 1'b0; M_HTRANS = 2'b00; M_HBURST = 3'b000; M_HSIZE = 3'd0; M_HADDR = '0;
    M_HWRITE = 1'b0; M_HPROT = 4'h0; M_HMASTLOCK = 1'b0;
    mux_accept = 1'b0; dphase_active = 1'b0; S_HREADY = 1'b1; S_HRESP = 1'b0;

    // Reset with a live NONSEQ on the master side: nothing must be requested
    rs = mk(2'b10, 3'b000, 3'd2, 32'h1000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    rs.rst_n = 1'b0;
    cycle(rs);
    cycle(rs);

    // pass-through
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 0));
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h1000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 1, 0, 1));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 0, 0, 0));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1, 0, 0));
    // hold for three wait states
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h2000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 1));
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h2000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 0, 0, 1));
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h2000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 0, 0, 1));
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h2000_0004, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 0, 0, 1));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 0, 0, 0));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1, 0, 0));
    // SEQ INCR4 beat held, replayed as NONSEQ INCR
    tbl.push_back(mv(mk(2'b11, 3'b011, 3'd2, 32'h2000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 1));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 0, 0, 1));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1, 0, 0));
    // slave two-cycle ERROR
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h4000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 1, 0, 1));
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h4000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1), 0, 1, 0));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 1, 1, 0));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 0));
    // misaligned word
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h3000_0002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1, 0, !CHK));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), !CHK, CHK, 0));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, CHK, 0));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 0));
    // oversized transfer, then a legal phase issued in ERR2 that gets held
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd3, 32'h3000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1, 0, !CHK));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), !CHK, CHK, 0));
    tbl.push_back(mv(mk(2'b10, 3'b000, 3'd2, 32'h3000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, CHK, 1));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 0, 0, 1));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 0));
    // BUSY is never requested or held
    tbl.push_back(mv(mk(2'b01, 3'b011, 3'd2, 32'h5000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 0));
    tbl.push_back(mv(mk(2'b00, 3'b000, 3'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].s);
      check($sformatf("tbl%0d_rdy", i), 64'(obs_rdy), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_rsp", i), 64'(obs_rsp), 64'(tbl[i].e_rsp));
      check($sformatf("tbl%0d_req", i), 64'(obs_req), 64'(tbl[i].e_req));
    end

    // Reset asserted mid-hold: outputs return to idle immediately, held phase is lost
    rs = mk(2'b10, 3'b000, 3'd2, 32'h6000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(rs);
    cycle(rs);
    #3 HRESETn = 1'b0;
    #1;
    check("rst_async_rdy", 64'(M_HREADYOUT), 64'(1));
    check("rst_async_req", 64'(out_req), 64'(0));
    check("rst_async_rsp", 64'(M_HRESP), 64'(0));
    rs.rst_n = 1'b0;
    cycle(rs);
    rs = mk(2'b00, 3'b000, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(rs);
    check("post_rst_req", 64'(obs_req), 64'(0));
    cycle(rs);
    check("post_rst_req2", 64'(obs_req), 64'(0));

    // Randomized cycles against the model
    for (int i = 0; i < 3000; i++) begin
      rs.rst_n  = ($urandom_range(0, 299) != 0);
      rs.htrans = 2'($urandom_range(0, 3));
      rs.hburst = 3'($urandom);
      rs.hsize  = 3'($urandom_range(0, 3));
      rs.haddr  = $urandom;
      if ($urandom_range(0, 3) != 0) rs.haddr[1:0] = 2'b00;
      rs.hwrite = 1'($urandom);
      rs.hprot  = 4'($urandom);
      rs.lock   = 1'($urandom);
      rs.acc    = 1'($urandom);
      rs.dph    = 1'($urandom);
      rs.shr    = ($urandom_range(0, 3) != 0);
      rs.shp    = ($urandom_range(0, 7) == 0);
      cycle(rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
